// File: rtl/mem_lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - memory op codes (LB..SW)
//   - LSU FSM state enum
//   - address-error exception codes
//   - small helpers for alignment checks and store lane formatting
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXC,
    S_DRAIN
  } lsu_state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SB);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return |lo;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_SB:   return 4'b0001 << lo;
      OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
      OP_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      OP_SB:   return {4{wdata[7:0]}};
      OP_SH:   return {2{wdata[15:0]}};
      OP_SW:   return wdata;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational little-endian load extraction.
// Ports:
//   rdata   in  32  raw word from memory
//   addr_lo in  2   byte offset of the load address
//   op      in  3   load op code (LB/LBU/LH/LHU/LW)
//   value   out 32  selected and sign/zero-extended result
module mem_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  value = {24'b0, byte_sel};
      OP_LH:   value = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  value = {16'b0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit, one transaction in flight.
// Ports:
//   clk, rst                      clock, async active-high reset
//   ex_valid/op/addr/wdata/wreg   request from EX; ex_ready back-pressure (high only in IDLE)
//   flush                         kill in-flight op
//   data_req/be/addr/wdata        registered memory request; data_gnt accepts it
//   data_rvalid/data_rdata        load response
//   done                          one-cycle completion pulse
//   wb_we/wb_wreg/wb_wdata        load writeback, valid with done
//   exc_valid/exc_code/exc_badvaddr address error, valid with done
module mem_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_wreg,
  output logic        ex_ready,
  input  logic        flush,
  output logic        data_req,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_badvaddr
);

  lsu_state_e  state;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  wreg_q;
  logic        accept;
  logic [31:0] load_val;

  assign ex_ready = (state == S_IDLE);
  // A flush in IDLE blocks the accept of that cycle.
  assign accept   = ex_valid & ex_ready & ~flush;

  mem_load_align u_align (
    .rdata   (data_rdata),
    .addr_lo (addr_lo_q),
    .op      (op_q),
    .value   (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      addr_lo_q    <= '0;
      wreg_q       <= '0;
      data_req     <= 1'b0;
      data_be      <= '0;
      data_addr    <= '0;
      data_wdata   <= '0;
      done         <= 1'b0;
      wb_we        <= 1'b0;
      wb_wreg      <= '0;
      wb_wdata     <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= '0;
      exc_badvaddr <= '0;
    end else begin
      // Completion outputs are single-cycle pulses and read zero otherwise.
      done         <= 1'b0;
      wb_we        <= 1'b0;
      wb_wreg      <= '0;
      wb_wdata     <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= '0;
      exc_badvaddr <= '0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= ex_op;
            addr_lo_q <= ex_addr[1:0];
            wreg_q    <= ex_wreg;
            if (misaligned(ex_op, ex_addr[1:0])) begin
              // Exception reported in the EXC cycle itself.
              state        <= S_EXC;
              done         <= 1'b1;
              exc_valid    <= 1'b1;
              exc_code     <= is_store(ex_op) ? EXC_ADES : EXC_ADEL;
              exc_badvaddr <= ex_addr;
            end else begin
              state      <= S_REQ;
              data_req   <= 1'b1;
              data_addr  <= {ex_addr[31:2], 2'b00};
              data_be    <= store_be(ex_op, ex_addr[1:0]);
              data_wdata <= store_wdata(ex_op, ex_wdata);
            end
          end
        end

        S_REQ: begin
          if (data_gnt) begin
            data_req <= 1'b0;
            if (is_store(op_q)) begin
              state <= S_IDLE;
              done  <= ~flush;
            end else begin
              // A granted load owes a response; drain it if flushed.
              state <= flush ? S_DRAIN : S_WAIT;
            end
          end else if (flush) begin
            data_req <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (data_rvalid) begin
            state <= S_IDLE;
            if (!flush) begin
              done     <= 1'b1;
              wb_we    <= 1'b1;
              wb_wreg  <= wreg_q;
              wb_wdata <= load_val;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end

        S_EXC: state <= S_IDLE;

        S_DRAIN: begin
          if (data_rvalid) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_wreg;
  logic        ex_ready;
  logic        flush;
  logic        data_req;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        done, wb_we, exc_valid;
  logic [4:0]  wb_wreg, exc_code;
  logic [31:0] wb_wdata, exc_badvaddr;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_wreg(ex_wreg), .ex_ready(ex_ready), .flush(flush),
    .data_req(data_req), .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .done(done), .wb_we(wb_we), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, set by the stimulus.
  logic        exp_ready, exp_req, exp_store, exp_done, exp_wb_we, exp_exc_valid;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_wb_wdata, exp_badvaddr;
  logic [4:0]  exp_wb_wreg, exp_exc_code;

  // Values captured from the DUT for literal pinning.
  logic [31:0] last_wb_wdata, last_data_addr, last_data_wdata, last_badvaddr;
  logic [3:0]  last_be;
  logic [4:0]  last_exc_code;
  int          req_cycles, ready_low_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic m_is_store(input logic [2:0] op);
    return (op == OP_SB || op == OP_SH || op == OP_SW);
  endfunction

  function automatic logic m_misal(input logic [2:0] op, input logic [31:0] addr);
    return (addr % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
    int sz = m_size(op);
    int a  = int'(addr % 4);
    int mask = (1 << sz) - 1;
    return 4'(mask << (a - a % sz));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] w);
    int sz = m_size(op);
    if (sz == 1) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int sz = m_size(op);
    int a  = int'(addr % 4);
    logic [31:0] v;
    a = a - a % sz;
    v = rd >> (8 * a);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_ready", ex_ready, exp_ready);
      chk("data_req", data_req, exp_req);
      if (exp_req) begin
        chk("data_addr", data_addr, exp_addr);
        chk("data_be", data_be, exp_be);
        if (exp_store) chk("data_wdata", data_wdata, exp_wdata);
      end
      chk("done", done, exp_done);
      chk("wb_we", wb_we, exp_wb_we);
      chk("wb_wreg", wb_wreg, exp_wb_wreg);
      chk("wb_wdata", wb_wdata, exp_wb_wdata);
      chk("exc_valid", exc_valid, exp_exc_valid);
      chk("exc_code", exc_code, exp_exc_code);
      chk("exc_badvaddr", exc_badvaddr, exp_badvaddr);
    end
    if (done) last_wb_wdata = wb_wdata;
    if (data_req) begin
      last_data_addr  = data_addr;
      last_be         = data_be;
      last_data_wdata = data_wdata;
      req_cycles++;
    end
    if (!ex_ready) ready_low_cycles++;
    if (exc_valid) begin
      last_exc_code = exc_code;
      last_badvaddr = exc_badvaddr;
    end
  end

  // Advance one cycle; inputs and expectations return to idle defaults.
  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid = 0; ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_wreg = '0;
    flush = 0; data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    exp_ready = 1; exp_req = 0; exp_store = 0; exp_done = 0; exp_wb_we = 0;
    exp_exc_valid = 0; exp_be = '0; exp_addr = '0; exp_wdata = '0;
    exp_wb_wdata = '0; exp_badvaddr = '0; exp_wb_wreg = '0; exp_exc_code = '0;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w);
    exp_ready = 0;
    exp_req   = 1;
    exp_store = m_is_store(op);
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_be    = m_is_store(op) ? m_be(op, addr) : 4'd0;
    exp_wdata = m_wdata(op, w);
  endtask

  // Complete transaction without flush; must start right after tick().
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w,
                       input logic [4:0] wreg, input int gnt_lat, input int rv_lat,
                       input logic [31:0] rd);
    ex_valid = 1; ex_op = op; ex_addr = addr; ex_wdata = w; ex_wreg = wreg;
    tick();
    if (m_misal(op, addr)) begin
      exp_ready = 0; exp_done = 1; exp_exc_valid = 1;
      exp_exc_code = m_is_store(op) ? 5'd5 : 5'd4;
      exp_badvaddr = addr;
      tick();
      return;
    end
    for (int i = 0; i <= gnt_lat; i++) begin
      set_req(op, addr, w);
      data_gnt = (i == gnt_lat);
      tick();
    end
    if (m_is_store(op)) begin
      exp_done = 1;
      tick();
      return;
    end
    for (int j = 0; j <= rv_lat; j++) begin
      exp_ready = 0;
      data_rvalid = (j == rv_lat);
      data_rdata  = (j == rv_lat) ? rd : 32'hDEADBEEF;
      tick();
    end
    exp_done = 1; exp_wb_we = 1; exp_wb_wreg = wreg;
    exp_wb_wdata = m_load(op, addr, rd);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    ex_valid = 0; ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_wreg = '0;
    flush = 0; data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    req_cycles = 0; ready_low_cycles = 0;
    tick();
    chk_en = 1;           // reset values checked while rst is held
    tick();
    rst = 0;
    tick();

    // Store byte
    do_op(OP_SB, 32'h0000_1003, 32'h0000_00A5, 5'd3, 0, 0, '0);
    chk("sb_addr_lit", last_data_addr, 32'h0000_1000);
    chk("sb_be_lit", last_be, 4'b1000);
    chk("sb_wdata_lit", last_data_wdata, 32'hA5A5_A5A5);

    // Store half, upper lane
    do_op(OP_SH, 32'h0000_2002, 32'h1234_BEEF, 5'd0, 0, 0, '0);
    chk("sh_be_lit", last_be, 4'b1100);
    chk("sh_wdata_lit", last_data_wdata, 32'hBEEF_BEEF);

    // Loads with extension
    do_op(OP_LB, 32'h0000_2002, '0, 5'd4, 0, 0, 32'h80FF_7F01);
    chk("lb_lit", last_wb_wdata, 32'hFFFF_FFFF);
    do_op(OP_LBU, 32'h0000_2002, '0, 5'd5, 0, 0, 32'h80FF_7F01);
    chk("lbu_lit", last_wb_wdata, 32'h0000_00FF);
    do_op(OP_LH, 32'h0000_2002, '0, 5'd6, 1, 0, 32'h80FF_7F01);
    chk("lh_lit", last_wb_wdata, 32'hFFFF_80FF);
    do_op(OP_LHU, 32'h0000_2000, '0, 5'd7, 0, 1, 32'h80FF_7F01);
    do_op(OP_LB, 32'h0000_2001, '0, 5'd8, 0, 0, 32'h80FF_7F01);
    do_op(OP_LW, 32'h0000_2000, '0, 5'd31, 0, 2, 32'hCAFE_F00D);

    // Misaligned
    req_cycles = 0;
    do_op(OP_LW, 32'h0000_3001, '0, 5'd9, 0, 0, '0);
    chk("lw_misal_code_lit", last_exc_code, 5'd4);
    chk("lw_misal_bad_lit", last_badvaddr, 32'h0000_3001);
    chk("lw_misal_noreq", req_cycles, 0);
    do_op(OP_SH, 32'h0000_3001, 32'h1, 5'd0, 0, 0, '0);
    chk("sh_misal_code_lit", last_exc_code, 5'd5);

    // Stalled memory: grant withheld for 3 cycles
    req_cycles = 0; ready_low_cycles = 0;
    do_op(OP_SW, 32'h0000_1008, 32'h0102_0304, 5'd0, 3, 0, '0);
    chk("stall_req_cycles", req_cycles, 4);
    chk("stall_ready_low", ready_low_cycles, 4);

    // Flush in WAIT, rvalid two cycles later, then a normal LW
    ex_valid = 1; ex_op = OP_LW; ex_addr = 32'h0000_4000; ex_wreg = 5'd7;
    tick();
    set_req(OP_LW, 32'h0000_4000, '0); data_gnt = 1;
    tick();
    exp_ready = 0; flush = 1;                // WAIT
    tick();
    exp_ready = 0;                           // DRAIN
    tick();
    exp_ready = 0; data_rvalid = 1; data_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    do_op(OP_LW, 32'h0000_4004, '0, 5'd9, 0, 1, 32'h1234_5678);
    chk("lw_after_flush_lit", last_wb_wdata, 32'h1234_5678);

    // Flush in REQ without grant
    ex_valid = 1; ex_op = OP_SW; ex_addr = 32'h0000_8000; ex_wdata = 32'h55;
    tick();
    set_req(OP_SW, 32'h0000_8000, 32'h55); flush = 1;
    tick();
    tick();

    // Flush in REQ together with a load grant -> drain
    ex_valid = 1; ex_op = OP_LBU; ex_addr = 32'h0000_7001; ex_wreg = 5'd2;
    tick();
    set_req(OP_LBU, 32'h0000_7001, '0); data_gnt = 1; flush = 1;
    tick();
    exp_ready = 0; data_rvalid = 1; data_rdata = 32'hFFFF_FFFF;
    tick();
    tick();

    // Flush coinciding with rvalid suppresses writeback
    ex_valid = 1; ex_op = OP_LH; ex_addr = 32'h0000_6002; ex_wreg = 5'd11;
    tick();
    set_req(OP_LH, 32'h0000_6002, '0); data_gnt = 1;
    tick();
    exp_ready = 0; data_rvalid = 1; data_rdata = 32'h8765_4321; flush = 1;
    tick();
    tick();

    // Flush in EXC: the registered exception still shows, then silent return
    ex_valid = 1; ex_op = OP_LW; ex_addr = 32'h0000_3002;
    tick();
    exp_ready = 0; exp_done = 1; exp_exc_valid = 1; exp_exc_code = 5'd4;
    exp_badvaddr = 32'h0000_3002; flush = 1;
    tick();
    tick();

    // Flush in IDLE blocks accept
    ex_valid = 1; ex_op = OP_SW; ex_addr = 32'h0000_9000; flush = 1;
    tick();
    tick();

    // Reset in REQ: outputs drop without a clock edge
    ex_valid = 1; ex_op = OP_SW; ex_addr = 32'h0000_5000; ex_wdata = 32'h77;
    tick();
    set_req(OP_SW, 32'h0000_5000, 32'h77);
    #6;
    chk_en = 0;
    rst = 1;
    #1;
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    tick();
    rst = 0;
    chk_en = 1;
    tick();
    do_op(OP_LB, 32'h0000_2003, '0, 5'd12, 0, 0, 32'h80FF_7F01);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
